// File: rtl/fdiv_if.sv
// Operand/result stb-ack bundle shared with the FPU multiplier; the CPU side is
// the master, the arithmetic unit the slave.
interface fdiv_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/fdiv.sv
// binary32 divider z = a / b (RNE, NaN/inf/zero/denormal), one op in flight; 3 edges b->z for
// specials, 38 for normal operands (+1 per normalise shift); output_z_ack=0 stalls in put_z, inputs not acked.
module fdiv (
  input  logic  clk,
  input  logic  rst,
  fdiv_if.slave bus
);

  typedef enum logic [3:0] {
    get_a, get_b, unpack, special_cases, normalise_a, normalise_b, divide_0,
    divide_1, divide_2, normalise_1, normalise_2, round, pack, put_z
  } state_t;

  state_t             state;
  logic [31:0]        a, b, z;
  logic [23:0]        a_m, b_m, z_m;
  logic signed [9:0]  a_e, b_e, z_e;
  logic               a_s, b_s, z_s;
  logic               guard, round_bit, sticky;
  logic [25:0]        rem;
  logic [26:0]        q;
  logic [4:0]         count;
  logic               a_ack, b_ack, z_stb;
  logic [31:0]        z_out;

  // operand classification, valid from special_cases onward
  logic a_max, b_max, a_min, b_min, a_mz, b_mz, a_zero, b_zero, a_nan, b_nan;
  logic        quo_bit;
  logic [25:0] rem_sub;
  logic [7:0]  exp_field;
  logic [31:0] pack_word;

  assign a_max  = (a_e == 10'sd128);
  assign b_max  = (b_e == 10'sd128);
  assign a_min  = (a_e == -10'sd127);
  assign b_min  = (b_e == -10'sd127);
  assign a_mz   = (a_m == 24'd0);
  assign b_mz   = (b_m == 24'd0);
  assign a_nan  = a_max && !a_mz;
  assign b_nan  = b_max && !b_mz;
  assign a_zero = a_min && a_mz;
  assign b_zero = b_min && b_mz;

  always_comb begin
    quo_bit = (rem >= {2'b00, b_m});
    rem_sub = rem - {2'b00, b_m};
  end

  // a quotient still below the smallest normal after shifting gets a zero exponent field
  always_comb begin
    exp_field = z_e[7:0] + 8'd127;
    pack_word = {z_s, exp_field, z_m[22:0]};
    if (z_e == -10'sd126 && !z_m[23]) pack_word[30:23] = 8'd0;
    if (z_e > 10'sd127)               pack_word = {z_s, 8'hFF, 23'd0};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= get_a;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      z_stb <= 1'b0;
      z_out <= 32'd0;
    end else begin
      case (state)
        get_a: begin
          a_ack <= 1'b1;
          if (a_ack && bus.input_a_stb) begin
            a     <= bus.input_a;
            a_ack <= 1'b0;
            state <= get_b;
          end
        end

        get_b: begin
          b_ack <= 1'b1;
          if (b_ack && bus.input_b_stb) begin
            b     <= bus.input_b;
            b_ack <= 1'b0;
            state <= unpack;
          end
        end

        unpack: begin
          a_m   <= {1'b0, a[22:0]};
          b_m   <= {1'b0, b[22:0]};
          a_e   <= $signed({2'b00, a[30:23]}) - 10'sd127;
          b_e   <= $signed({2'b00, b[30:23]}) - 10'sd127;
          a_s   <= a[31];
          b_s   <= b[31];
          state <= special_cases;
        end

        special_cases: begin
          state <= put_z;
          if (a_nan || b_nan)           z <= 32'hFFC0_0000;
          else if (a_max && b_max)      z <= 32'hFFC0_0000;
          else if (a_max)               z <= {a_s ^ b_s, 8'hFF, 23'd0};
          else if (b_max)               z <= {a_s ^ b_s, 31'd0};
          else if (a_zero && b_zero)    z <= 32'hFFC0_0000;
          else if (b_zero)              z <= {a_s ^ b_s, 8'hFF, 23'd0};
          else if (a_zero)              z <= {a_s ^ b_s, 31'd0};
          else begin
            // denormals keep the hidden bit clear and sit at the minimum exponent
            if (a_min) a_e <= -10'sd126;
            else       a_m[23] <= 1'b1;
            if (b_min) b_e <= -10'sd126;
            else       b_m[23] <= 1'b1;
            state <= normalise_a;
          end
        end

        normalise_a: begin
          if (a_m[23]) state <= normalise_b;
          else begin
            a_m <= a_m << 1;
            a_e <= a_e - 10'sd1;
          end
        end

        normalise_b: begin
          if (b_m[23]) state <= divide_0;
          else begin
            b_m <= b_m << 1;
            b_e <= b_e - 10'sd1;
          end
        end

        divide_0: begin
          z_s   <= a_s ^ b_s;
          z_e   <= a_e - b_e;
          rem   <= {2'b00, a_m};
          q     <= 27'd0;
          count <= 5'd0;
          state <= divide_1;
        end

        // restoring division, MSB first: q ends as floor(a_m * 2^26 / b_m)
        divide_1: begin
          q     <= {q[25:0], quo_bit};
          rem   <= quo_bit ? (rem_sub << 1) : (rem << 1);
          count <= count + 5'd1;
          if (count == 5'd26) state <= divide_2;
        end

        divide_2: begin
          z_m       <= q[26:3];
          guard     <= q[2];
          round_bit <= q[1];
          sticky    <= q[0] | (rem != 26'd0);
          state     <= normalise_1;
        end

        normalise_1: begin
          if (z_m[23]) state <= normalise_2;
          else begin
            z_m       <= {z_m[22:0], guard};
            guard     <= round_bit;
            round_bit <= 1'b0;
            z_e       <= z_e - 10'sd1;
          end
        end

        // right-shift into the denormal range, funnelling lost bits into guard/round/sticky
        normalise_2: begin
          if (z_e < -10'sd126) begin
            z_m       <= z_m >> 1;
            z_e       <= z_e + 10'sd1;
            guard     <= z_m[0];
            round_bit <= guard;
            sticky    <= sticky | round_bit;
          end else begin
            state <= round;
          end
        end

        round: begin
          if (guard && (round_bit || sticky || z_m[0])) begin
            z_m <= z_m + 24'd1;
            if (z_m == 24'hFF_FFFF) z_e <= z_e + 10'sd1;
          end
          state <= pack;
        end

        pack: begin
          z     <= pack_word;
          state <= put_z;
        end

        put_z: begin
          z_stb <= 1'b1;
          z_out <= z;
          if (z_stb && bus.output_z_ack) begin
            z_stb <= 1'b0;
            state <= get_a;
          end
        end

        default: state <= get_a;
      endcase
    end
  end

  assign bus.input_a_ack  = a_ack;
  assign bus.input_b_ack  = b_ack;
  assign bus.output_z_stb = z_stb;
  assign bus.output_z     = z_out;

endmodule
